// File: rtl/carfield_addr_map_pkg.sv
// Shared types for the Carfield dynamic address map: region record, config field
// encoding and the reset-image array type.
package carfield_addr_map_pkg;

  localparam int unsigned MaxRegions   = 32;
  localparam int unsigned MaxAddrWidth = 64;

  typedef struct packed {
    logic                    enable;
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] size;
  } region_t;

  typedef enum logic [1:0] {
    FieldBase   = 2'd0,
    FieldSize   = 2'd1,
    FieldEnable = 2'd2,
    FieldLock   = 2'd3
  } field_e;

  // Reset image; only the low NumRegions entries are used by an instance.
  typedef region_t [MaxRegions-1:0] default_map_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carfield_addr_map_match.sv
// Combinational region compare and lowest-index priority encoder.
module carfield_addr_map_match
  import carfield_addr_map_pkg::*;
#(
  parameter int unsigned NumRegions = 8,
  parameter int unsigned AddrWidth  = 64,
  localparam int unsigned IdxW      = idx_width(NumRegions)
) (
  input  region_t [NumRegions-1:0] map,
  input  logic [AddrWidth-1:0]     addr,
  output logic                     hit,
  output logic [IdxW-1:0]          idx,
  output logic                     multi
);

  logic [NumRegions-1:0] match;

  // Offset compare avoids any wrap of base + size.
  for (genvar i = 0; i < NumRegions; i++) begin : g_cmp
    logic [AddrWidth-1:0] base;
    logic [AddrWidth-1:0] size;
    logic [AddrWidth-1:0] off;
    assign base     = map[i].base[AddrWidth-1:0];
    assign size     = map[i].size[AddrWidth-1:0];
    assign off      = addr - base;
    assign match[i] = map[i].enable && (addr >= base) && (off < size);
  end

  always_comb begin
    idx = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (match[i]) idx = i[IdxW-1:0];
    end
  end

  assign hit   = |match;
  assign multi = |(match & (match - 1'b1));

endmodule

// File: rtl/carfield_dyn_addr_map.sv
// Double-banked address map with drained shadow-to-active commit and a registered
// lookup stage. Define CARFIELD_ADDR_MAP_LOCK_EN to add per-region lock bits on field 3.
module carfield_dyn_addr_map
  import carfield_addr_map_pkg::*;
#(
  parameter int unsigned  NumRegions = 8,
  parameter int unsigned  AddrWidth  = 64,
  parameter default_map_t DefaultMap = '0,
  localparam int unsigned IdxW       = idx_width(NumRegions)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_write_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 commit_i,
  output logic                 commit_busy_o,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_valid_o,
  input  logic                 lkp_ready_i,
  output logic                 lkp_hit_o,
  output logic [IdxW-1:0]      lkp_idx_o,
  output logic                 lkp_multi_o
);

  typedef enum logic [1:0] {Idle, Drain, Swap} commit_state_e;

  commit_state_e             state_q, state_d;
  region_t [NumRegions-1:0]  shadow_q, active_q, lkp_map;
  region_t                   cfg_region;
  field_e                    cfg_field;
  logic [IdxW-1:0]           cfg_sel;
  logic                      cfg_idx_ok, cfg_field_ok, cfg_locked, lock_rd, cfg_we;
  logic                      lkp_accept, m_hit, m_multi;
  logic [IdxW-1:0]           m_idx;

  assign cfg_field  = field_e'(cfg_field_i);
  assign cfg_idx_ok = 32'(cfg_idx_i) < NumRegions;
  assign cfg_sel    = cfg_idx_ok ? cfg_idx_i : '0;
  assign cfg_region = shadow_q[cfg_sel];

`ifdef CARFIELD_ADDR_MAP_LOCK_EN
  logic [NumRegions-1:0] lock_q;

  assign cfg_field_ok = 1'b1;
  assign cfg_locked   = lock_q[cfg_sel];
  assign lock_rd      = lock_q[cfg_sel];

  // Sticky until reset: software can only ever tighten protection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= '0;
    end else if (cfg_valid_i && cfg_write_i && cfg_idx_ok &&
                 cfg_field == FieldLock && cfg_wdata_i[0]) begin
      lock_q[cfg_sel] <= 1'b1;
    end
  end
`else
  assign cfg_field_ok = (cfg_field != FieldLock);
  assign cfg_locked   = 1'b0;
  assign lock_rd      = 1'b0;
`endif

  assign cfg_ready_o = 1'b1;
  assign cfg_err_o   = cfg_valid_i &&
                       (!cfg_idx_ok || !cfg_field_ok ||
                        (cfg_write_i && cfg_locked && cfg_field != FieldLock));
  assign cfg_we      = cfg_valid_i && cfg_write_i && !cfg_err_o;

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg_idx_ok) begin
      case (cfg_field)
        FieldBase:   cfg_rdata_o = cfg_region.base[AddrWidth-1:0];
        FieldSize:   cfg_rdata_o = cfg_region.size[AddrWidth-1:0];
        FieldEnable: cfg_rdata_o = AddrWidth'(cfg_region.enable);
        default:     cfg_rdata_o = AddrWidth'(lock_rd);
      endcase
    end
  end

  // Copy takes the pre-write shadow, so a same-cycle cfg write is not committed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegions; i++) begin
        shadow_q[i] <= DefaultMap[i];
        active_q[i] <= DefaultMap[i];
      end
    end else begin
      if (state_q == Swap) active_q <= shadow_q;
      if (cfg_we) begin
        case (cfg_field)
          FieldBase:   shadow_q[cfg_sel].base   <= MaxAddrWidth'(cfg_wdata_i);
          FieldSize:   shadow_q[cfg_sel].size   <= MaxAddrWidth'(cfg_wdata_i);
          FieldEnable: shadow_q[cfg_sel].enable <= cfg_wdata_i[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Idle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Idle:    if (commit_i) state_d = Drain;
      Drain:   if (!lkp_valid_o || lkp_ready_i) state_d = Swap;
      Swap:    state_d = Idle;
      default: state_d = Idle;
    endcase
  end

  assign commit_busy_o = (state_q != Idle);
  assign lkp_ready_o   = (state_q != Drain) && (!lkp_valid_o || lkp_ready_i);
  assign lkp_accept    = lkp_valid_i && lkp_ready_o;

  // During Swap the shadow bank is exactly what active becomes at the edge.
  assign lkp_map = (state_q == Swap) ? shadow_q : active_q;

  carfield_addr_map_match #(
    .NumRegions (NumRegions),
    .AddrWidth  (AddrWidth)
  ) u_match (
    .map   (lkp_map),
    .addr  (lkp_addr_i),
    .hit   (m_hit),
    .idx   (m_idx),
    .multi (m_multi)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lkp_valid_o <= 1'b0;
      lkp_hit_o   <= 1'b0;
      lkp_idx_o   <= '0;
      lkp_multi_o <= 1'b0;
    end else if (lkp_accept) begin
      lkp_valid_o <= 1'b1;
      lkp_hit_o   <= m_hit;
      lkp_idx_o   <= m_idx;
      lkp_multi_o <= m_multi;
    end else if (lkp_ready_i) begin
      lkp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carfield_dyn_addr_map.sv
// Scoreboard bench for carfield_dyn_addr_map; lock checks compile in with
// CARFIELD_ADDR_MAP_LOCK_EN.
module tb_carfield_dyn_addr_map;
  import carfield_addr_map_pkg::*;

  localparam int unsigned NumRegions = 6;
  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned IdxW       = idx_width(NumRegions);

  function automatic default_map_t mk_map();
    default_map_t m;
    m    = '0;
    m[0] = '{enable: 1'b1, base: 64'h2000_1000, size: 64'h9000};
    return m;
  endfunction

  localparam default_map_t TbMap = mk_map();

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 cfg_valid_i = 1'b0, cfg_ready_o, cfg_write_i = 1'b0;
  logic [IdxW-1:0]      cfg_idx_i = '0;
  logic [1:0]           cfg_field_i = '0;
  logic [AddrWidth-1:0] cfg_wdata_i = '0, cfg_rdata_o;
  logic                 cfg_err_o, commit_i = 1'b0, commit_busy_o;
  logic                 lkp_valid_i = 1'b0, lkp_ready_o;
  logic [AddrWidth-1:0] lkp_addr_i = '0;
  logic                 lkp_valid_o, lkp_ready_i = 1'b1;
  logic                 lkp_hit_o, lkp_multi_o;
  logic [IdxW-1:0]      lkp_idx_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic            hit;
    logic [IdxW-1:0] idx;
    logic            multi;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_exp;

  carfield_dyn_addr_map #(
    .NumRegions (NumRegions),
    .AddrWidth  (AddrWidth),
    .DefaultMap (TbMap)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_write_i   (cfg_write_i),
    .cfg_idx_i     (cfg_idx_i),
    .cfg_field_i   (cfg_field_i),
    .cfg_wdata_i   (cfg_wdata_i),
    .cfg_rdata_o   (cfg_rdata_o),
    .cfg_err_o     (cfg_err_o),
    .commit_i      (commit_i),
    .commit_busy_o (commit_busy_o),
    .lkp_valid_i   (lkp_valid_i),
    .lkp_ready_o   (lkp_ready_o),
    .lkp_addr_i    (lkp_addr_i),
    .lkp_valid_o   (lkp_valid_o),
    .lkp_ready_i   (lkp_ready_i),
    .lkp_hit_o     (lkp_hit_o),
    .lkp_idx_o     (lkp_idx_o),
    .lkp_multi_o   (lkp_multi_o)
  );

  always #5 clk = ~clk;

  // Response scoreboard: every consumed response is matched against the queue.
  always @(negedge clk) begin
    if (rst_ni && lkp_valid_o && lkp_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got hit=%0b idx=%0d multi=%0b, required no response",
                 lkp_hit_o, lkp_idx_o, lkp_multi_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({lkp_hit_o, lkp_idx_o, lkp_multi_o} !== mon_exp) begin
          errors++;
          $display("FAIL resp: got hit=%0b idx=%0d multi=%0b, required hit=%0b idx=%0d multi=%0b",
                   lkp_hit_o, lkp_idx_o, lkp_multi_o, mon_exp.hit, mon_exp.idx, mon_exp.multi);
        end
      end
    end
  end

  // All drivers start and end 1 time unit after a rising edge.
  task automatic cfg_access(input logic wr, input logic [IdxW-1:0] idx, input logic [1:0] field,
                            input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
    cfg_valid_i = 1'b1;
    cfg_write_i = wr;
    cfg_idx_i   = idx;
    cfg_field_i = field;
    cfg_wdata_i = wdata;
    #1;
    rdata = cfg_rdata_o;
    err   = cfg_err_o;
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
    cfg_write_i = 1'b0;
  endtask

  task automatic write_region(input logic [IdxW-1:0] idx, input logic [63:0] base,
                              input logic [63:0] size, input logic en, output logic any_err);
    logic [63:0] rd;
    logic e0, e1, e2;
    cfg_access(1'b1, idx, 2'd0, base, rd, e0);
    cfg_access(1'b1, idx, 2'd1, size, rd, e1);
    cfg_access(1'b1, idx, 2'd2, 64'(en), rd, e2);
    any_err = e0 | e1 | e2;
  endtask

  task automatic send_lookup(input logic [63:0] addr, input logic hit, input int idx,
                             input logic multi);
    bit done;
    exp_q.push_back('{hit: hit, idx: idx[IdxW-1:0], multi: multi});
    lkp_valid_i = 1'b1;
    lkp_addr_i  = addr;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (lkp_ready_o) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    lkp_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL lkp_accept_timeout: got ready=0 for 50 cycles, required acceptance");
    end
  endtask

  task automatic do_commit();
    int c;
    commit_i = 1'b1;
    @(posedge clk); #1;
    commit_i = 1'b0;
    c = 0;
    while (commit_busy_o && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    if (commit_busy_o) begin
      checks++;
      errors++;
      $display("FAIL commit_timeout: got busy=1, required 0 within 20 cycles");
    end
  endtask

  task automatic test_reset();
    logic [63:0] rd;
    logic e;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (lkp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", lkp_valid_o); end
    if (lkp_hit_o !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b, required 0", lkp_hit_o); end
    if (lkp_idx_o !== '0) begin errors++; $display("FAIL rst_idx: got %0d, required 0", lkp_idx_o); end
    if (lkp_multi_o !== 1'b0) begin errors++; $display("FAIL rst_multi: got %b, required 0", lkp_multi_o); end
    if (commit_busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", commit_busy_o); end
    if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL rst_cfg_err: got %b, required 0", cfg_err_o); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
    cfg_access(1'b0, 0, 2'd0, 64'h0, rd, e);
    checks++;
    if (rd !== 64'h2000_1000 || e !== 1'b0) begin
      errors++;
      $display("FAIL rst_shadow_base: got %h err=%b, required 20001000 err=0", rd, e);
    end
    cfg_access(1'b0, 0, 2'd2, 64'h0, rd, e);
    checks++;
    if (rd !== 64'h1) begin errors++; $display("FAIL rst_shadow_en: got %h, required 1", rd); end
  endtask

  task automatic test_default_map();
    send_lookup(64'h2000_4000, 1'b1, 0, 1'b0);
    checks++;
    if (lkp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL lkp_latency: got valid=%b one cycle after accept, required 1", lkp_valid_o);
    end
    send_lookup(64'h2000_0FFF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_shadow_commit();
    logic e;
    logic [63:0] rd;
    write_region(1, 64'h5000_0000, 64'h80_0000, 1'b1, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL shadow_wr_err: got %b, required 0", e); end
    cfg_access(1'b0, 1, 2'd1, 64'h0, rd, e);
    checks++;
    if (rd !== 64'h80_0000) begin errors++; $display("FAIL shadow_size_rd: got %h, required 800000", rd); end
    send_lookup(64'h5000_0010, 1'b0, 0, 1'b0);
    do_commit();
    send_lookup(64'h5000_0010, 1'b1, 1, 1'b0);
    send_lookup(64'h507F_FFFF, 1'b1, 1, 1'b0);
  endtask

  task automatic test_overlap();
    logic e2, e5;
    write_region(2, 64'h4000_0000, 64'h1000, 1'b1, e2);
    write_region(5, 64'h3FFF_F000, 64'h2000, 1'b1, e5);
    do_commit();
    send_lookup(64'h4000_0000, 1'b1, 2, 1'b1);
    send_lookup(64'h3FFF_F800, 1'b1, 5, 1'b0);
    send_lookup(64'h4000_1000, 1'b0, 0, 1'b0);
  endtask

  task automatic test_boundary();
    logic e;
    logic [63:0] rd;
    write_region(3, 64'h7800_0000, 64'h20_0000, 1'b1, e);
    write_region(4, 64'h6000_0000, 64'h0, 1'b1, e);
    do_commit();
    send_lookup(64'h781F_FFFF, 1'b1, 3, 1'b0);
    send_lookup(64'h7820_0000, 1'b0, 0, 1'b0);
    send_lookup(64'h7800_0000, 1'b1, 3, 1'b0);
    send_lookup(64'h6000_0000, 1'b0, 0, 1'b0);
    cfg_access(1'b0, 3'(NumRegions), 2'd0, 64'h0, rd, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL cfg_idx_range: got err=%b, required 1", e); end
    cfg_access(1'b1, 3'(NumRegions), 2'd0, 64'h1234, rd, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL cfg_idx_range_wr: got err=%b, required 1", e); end
`ifndef CARFIELD_ADDR_MAP_LOCK_EN
    cfg_access(1'b1, 0, 2'd3, 64'h1, rd, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL cfg_reserved_field: got err=%b, required 1", e); end
`endif
  endtask

  task automatic test_commit_stall();
    logic e;
    logic [63:0] rd;
    int busy_cycles;
    int k;
    lkp_ready_i = 1'b0;
    send_lookup(64'h2000_4000, 1'b1, 0, 1'b0);
    cfg_access(1'b1, 0, 2'd2, 64'h0, rd, e);
    commit_i = 1'b1;
    @(posedge clk); #1;
    commit_i = 1'b0;
    busy_cycles = 0;
    k = 0;
    while (commit_busy_o && k < 20) begin
      busy_cycles++;
      if (k < 3) begin
        checks++;
        if (lkp_valid_o !== 1'b1 || lkp_hit_o !== 1'b1 || lkp_idx_o !== '0 || lkp_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b hit=%b idx=%0d ready=%b, required 1 1 0 0",
                   lkp_valid_o, lkp_hit_o, lkp_idx_o, lkp_ready_o);
        end
      end
      if (k == 3) lkp_ready_i = 1'b1;
      k++;
      @(posedge clk); #1;
    end
    lkp_ready_i = 1'b1;
    checks++;
    if (busy_cycles != 5) begin
      errors++;
      $display("FAIL commit_busy_len: got %0d cycles, required 5", busy_cycles);
    end
    send_lookup(64'h2000_4000, 1'b0, 0, 1'b0);
  endtask

`ifdef CARFIELD_ADDR_MAP_LOCK_EN
  task automatic test_lock();
    logic e;
    logic [63:0] rd;
    cfg_access(1'b1, 0, 2'd3, 64'h1, rd, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL lock_set_err: got %b, required 0", e); end
    cfg_access(1'b1, 0, 2'd0, 64'hDEAD_0000, rd, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL lock_wr_err: got %b, required 1", e); end
    cfg_access(1'b0, 0, 2'd0, 64'h0, rd, e);
    checks++;
    if (rd !== 64'h2000_1000) begin errors++; $display("FAIL lock_readback: got %h, required 20001000", rd); end
    cfg_access(1'b0, 0, 2'd3, 64'h0, rd, e);
    checks++;
    if (rd !== 64'h1 || e !== 1'b0) begin
      errors++;
      $display("FAIL lock_bit_rd: got %h err=%b, required 1 err=0", rd, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_map();
    test_shadow_commit();
    test_overlap();
    test_boundary();
    test_commit_stall();
`ifdef CARFIELD_ADDR_MAP_LOCK_EN
    test_lock();
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL resp_missing: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
